// File: rtl/aes_ctrl_pkg.sv
// Shared types for the AES request arbiter: data width, FSM states and
// the response record returned to the requesters.
package aes_ctrl_pkg;

  localparam int AES_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } aes_ctrl_state_t;

  typedef struct packed {
    logic             id;
    logic             timeout;
    logic [AES_W-1:0] data;
  } aes_rsp_t;

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin grant. Purely combinational; the caller keeps the
// last_grant register and updates it only when a grant is consumed.
module aes_rr_arb2 (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last_grant,
  output logic o_grant,
  output logic o_any_valid
);

  assign o_any_valid = i_valid0 | i_valid1;
  // A lone requester wins outright; on contention the one not served last wins.
  assign o_grant     = (i_valid0 & i_valid1) ? ~i_last_grant : i_valid1;

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one AES core between two requesters: accepts a job, drives and
// holds the core inputs while it computes, returns the tagged ciphertext
// (or a timeout marker when the core never answers), then gives the core
// one idle cycle to re-arm before the next job.
module aes_req_arbiter
  import aes_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic             AES_clk,
  input  logic             AES_rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [AES_W-1:0] req0_data,
  input  logic [AES_W-1:0] req0_key,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [AES_W-1:0] req1_data,
  input  logic [AES_W-1:0] req1_key,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [AES_W-1:0] rsp_data,
  output logic             rsp_timeout,
  output logic             core_en,
  output logic [AES_W-1:0] core_data_in,
  output logic [AES_W-1:0] core_key_in,
  input  logic [AES_W-1:0] core_data_out,
  input  logic             core_data_out_valid,
  output logic             busy
);

  // Watchdog fires on the last permitted RUN cycle.
  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  aes_ctrl_state_t  r_state;
  aes_ctrl_state_t  w_state_nxt;
  logic             r_last_grant;
  logic             r_id_q;
  logic             r_core_en;
  logic             r_rsp_valid;
  logic [CNT_W-1:0] r_cnt;
  logic [AES_W-1:0] r_core_data;
  logic [AES_W-1:0] r_core_key;
  aes_rsp_t         r_rsp;

  logic w_grant;
  logic w_any_valid;
  logic w_accept;
  logic w_done;
  logic w_timeout;

  aes_rr_arb2 u_arb (
    .i_valid0     (req0_valid),
    .i_valid1     (req1_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_any_valid  (w_any_valid)
  );

  // Ready is offered only in IDLE, and only to the granted, valid requester.
  assign req0_ready = (r_state == IDLE) && w_any_valid && !w_grant;
  assign req1_ready = (r_state == IDLE) && w_any_valid &&  w_grant;

  // Next-state decode and the single-cycle event strobes for the datapath.
  always_comb begin
    // NOTE: every signal is defaulted before the case so no path can infer a latch.
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        // Core valid takes precedence over a coincident watchdog expiry.
        if (core_data_out_valid) begin
          w_done      = 1'b1;
          w_state_nxt = RESP;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) w_state_nxt = GAP;
      end
      GAP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  // Job capture, watchdog, core drive and response registers.
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      r_last_grant <= 1'b1;
      r_id_q       <= 1'b0;
      r_cnt        <= '0;
      r_core_en    <= 1'b0;
      r_core_data  <= '0;
      r_core_key   <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp        <= '0;
    end else begin
      // NOTE: non-blocking assignments let every register see pre-edge values.
      if (w_accept) begin
        r_core_data  <= w_grant ? req1_data : req0_data;
        r_core_key   <= w_grant ? req1_key  : req0_key;
        r_id_q       <= w_grant;
        r_last_grant <= w_grant;
        r_cnt        <= '0;
        r_core_en    <= 1'b1;
      end
      if (r_state == RUN) r_cnt <= r_cnt + CNT_W'(1);
      if (w_done || w_timeout) begin
        r_core_en     <= 1'b0;
        r_rsp_valid   <= 1'b1;
        r_rsp.id      <= r_id_q;
        r_rsp.timeout <= w_timeout;
        r_rsp.data    <= w_done ? core_data_out : '0;
      end
      if ((r_state == RESP) && rsp_ready) r_rsp_valid <= 1'b0;
    end
  end

  assign core_en      = r_core_en;
  assign core_data_in = r_core_data;
  assign core_key_in  = r_core_key;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_rsp.id;
  assign rsp_data     = r_rsp.data;
  assign rsp_timeout  = r_rsp.timeout;
  assign busy         = (r_state != IDLE);

endmodule
